adc_chain_spi_arb_max11040: RTL and testbench

- Arbiter/sequencer sharing one byte-level SPI master between the MAX11040 config-write engine (cfg port) and the sample-read engine (rd port).
- Grants exclusive bus ownership, muxes CS/enable/data to the master and routes finish/rx back to the owner only.
- Enforces a minimum CS-high gap between owners and blocks reads until configuration has completed.
- Watchdog forces release and flags an error if the owner stalls.

---
 rtl/adc_chain_spi_arb_max11040_pkg.sv | 30 +++
 rtl/adc_spi_watchdog.sv | 41 ++++
 rtl/adc_chain_spi_arb_max11040.sv | 169 ++++++++++++++++
 tb/tb_adc_chain_spi_arb_max11040.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_chain_spi_arb_max11040_pkg.sv
// Shared encodings for the MAX11040 SPI bus arbiter: FSM states, owner codes,
// and the idle level driven onto the shared master when nobody owns the bus.
package adc_chain_spi_arb_max11040_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GNT_CFG = 3'd1,
    ST_GNT_RD  = 3'd2,
    ST_GAP     = 3'd3,
    ST_HOLD    = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CFG  = 2'b01,
    OWN_RD   = 2'b10
  } owner_e;

  // CS deasserted and data lines parked high while the bus is unowned
  localparam logic SPI_IDLE_BIT = 1'b1;

  function automatic owner_e state_owner(input arb_state_e s);
    case (s)
      ST_GNT_CFG: state_owner = OWN_CFG;
      ST_GNT_RD:  state_owner = OWN_RD;
      default:    state_owner = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/adc_spi_watchdog.sv
// Ownership watchdog: restarts on every rising edge of the master finish flag
// and raises expire_o when the owner has gone TIMEOUT_CYC cycles without one.
module adc_spi_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned TO_W        = 13
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic finsh_i,
  output logic expire_o
);

  logic            fin_q;
  logic            rise_q;
  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Counter sits at zero whenever nobody is granted, so a fresh grant starts clean
  always_comb begin
    cnt_d = cnt_q + TO_W'(1);
    if (!run_i || rise_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fin_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      fin_q  <= finsh_i;
      rise_q <= finsh_i & ~fin_q;
      cnt_q  <= cnt_d;
    end
  end

  assign expire_o = run_i && !rise_q && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/adc_chain_spi_arb_max11040.sv
// Arbiter between the MAX11040 config-write and sample-read engines sharing a
// single byte SPI master: exclusive grant, CS-high gap, read gating, watchdog.
module adc_chain_spi_arb_max11040
  import adc_chain_spi_arb_max11040_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned TO_W        = 13
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cfg_req_h,
  output logic                  cfg_gnt_h,
  input  logic                  cfg_cs_l,
  input  logic                  cfg_spi_en_hp,
  input  logic [DATA_WIDTH-1:0] cfg_spi_data,
  output logic                  cfg_spi_finsh_h,
  input  logic                  cfg_done_h,
  input  logic                  rd_req_h,
  output logic                  rd_gnt_h,
  input  logic                  rd_cs_l,
  input  logic                  rd_spi_en_hp,
  input  logic [DATA_WIDTH-1:0] rd_spi_data,
  output logic                  rd_spi_finsh_h,
  output logic [DATA_WIDTH-1:0] rd_spi_datain,
  output logic                  spi_cs_l,
  output logic                  spi_en_hp,
  output logic [DATA_WIDTH-1:0] spi_data,
  input  logic                  spi_finsh_h,
  input  logic [DATA_WIDTH-1:0] spi_datain,
  output logic                  busy_h,
  output logic [1:0]            owner,
  output logic                  timeout_err_hp
);

  localparam int unsigned GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           hold_src_q, hold_src_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             rd_allow_q, rd_allow_d;
  logic             err_q, err_d;
  logic             pick_cfg, pick_rd, gap_last, granted, expire;

  assign granted  = (state_q == ST_GNT_CFG) || (state_q == ST_GNT_RD);
  assign pick_cfg = cfg_req_h;
  assign pick_rd  = !cfg_req_h && rd_req_h && rd_allow_q;
  assign gap_last = (gap_cnt_q == GAP_W'(GAP_CYC - 1));

  adc_spi_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_wdog (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .run_i    (granted),
    .finsh_i  (spi_finsh_h),
    .expire_o (expire)
  );

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    hold_src_d = hold_src_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_cfg)     state_d = ST_GNT_CFG;
        else if (pick_rd) state_d = ST_GNT_RD;
      end
      ST_GNT_CFG: begin
        if (!cfg_req_h) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else if (expire) begin
          state_d    = ST_HOLD;
          hold_src_d = OWN_CFG;
        end
      end
      ST_GNT_RD: begin
        if (!rd_req_h) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else if (expire) begin
          state_d    = ST_HOLD;
          hold_src_d = OWN_RD;
        end
      end
      ST_GAP: begin
        // Pending requests are granted straight from the last gap cycle so CS
        // stays high for exactly GAP_CYC cycles between owners.
        if (gap_last) begin
          gap_cnt_d = '0;
          if (pick_cfg)     state_d = ST_GNT_CFG;
          else if (pick_rd) state_d = ST_GNT_RD;
          else              state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_HOLD: begin
        if ((hold_src_q == OWN_CFG && !cfg_req_h) ||
            (hold_src_q == OWN_RD  && !rd_req_h)) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    owner_d = state_owner(state_d);
    err_d   = (state_d == ST_HOLD) && (state_q != ST_HOLD);
    // A new configuration pass invalidates reads until cfg_done_h reasserts
    if (state_d == ST_GNT_CFG && state_q != ST_GNT_CFG) rd_allow_d = 1'b0;
    else if (cfg_done_h)                                rd_allow_d = 1'b1;
    else                                                rd_allow_d = rd_allow_q;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      hold_src_q <= OWN_NONE;
      gap_cnt_q  <= '0;
      rd_allow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_src_q <= hold_src_d;
      gap_cnt_q  <= gap_cnt_d;
      rd_allow_q <= rd_allow_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    spi_cs_l        = SPI_IDLE_BIT;
    spi_en_hp       = 1'b0;
    spi_data        = {DATA_WIDTH{SPI_IDLE_BIT}};
    cfg_spi_finsh_h = 1'b0;
    rd_spi_finsh_h  = 1'b0;
    rd_spi_datain   = '0;
    case (owner_q)
      OWN_CFG: begin
        spi_cs_l        = cfg_cs_l;
        spi_en_hp       = cfg_spi_en_hp;
        spi_data        = cfg_spi_data;
        cfg_spi_finsh_h = spi_finsh_h;
      end
      OWN_RD: begin
        spi_cs_l       = rd_cs_l;
        spi_en_hp      = rd_spi_en_hp;
        spi_data       = rd_spi_data;
        rd_spi_finsh_h = spi_finsh_h;
        rd_spi_datain  = spi_datain;
      end
      default: ;
    endcase
  end

  assign cfg_gnt_h      = (owner_q == OWN_CFG);
  assign rd_gnt_h       = (owner_q == OWN_RD);
  assign owner          = owner_q;
  assign busy_h         = (state_q != ST_IDLE);
  assign timeout_err_hp = err_q;

endmodule

// File: tb/tb_adc_chain_spi_arb_max11040.sv
// Self-checking bench for the MAX11040 SPI arbiter (GAP_CYC=4, TIMEOUT_CYC=16).
module tb_adc_chain_spi_arb_max11040;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       cfg_req_h, cfg_gnt_h, cfg_cs_l, cfg_spi_en_hp, cfg_spi_finsh_h, cfg_done_h;
  logic [7:0] cfg_spi_data;
  logic       rd_req_h, rd_gnt_h, rd_cs_l, rd_spi_en_hp, rd_spi_finsh_h;
  logic [7:0] rd_spi_data, rd_spi_datain;
  logic       spi_cs_l, spi_en_hp, spi_finsh_h;
  logic [7:0] spi_data, spi_datain;
  logic       busy_h, timeout_err_hp;
  logic [1:0] owner;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] rx_q[$];
  logic [1:0] own_q[$];

  adc_chain_spi_arb_max11040 #(
    .DATA_WIDTH  (8),
    .GAP_CYC     (4),
    .TIMEOUT_CYC (16),
    .TO_W        (13)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .cfg_req_h       (cfg_req_h),
    .cfg_gnt_h       (cfg_gnt_h),
    .cfg_cs_l        (cfg_cs_l),
    .cfg_spi_en_hp   (cfg_spi_en_hp),
    .cfg_spi_data    (cfg_spi_data),
    .cfg_spi_finsh_h (cfg_spi_finsh_h),
    .cfg_done_h      (cfg_done_h),
    .rd_req_h        (rd_req_h),
    .rd_gnt_h        (rd_gnt_h),
    .rd_cs_l         (rd_cs_l),
    .rd_spi_en_hp    (rd_spi_en_hp),
    .rd_spi_data     (rd_spi_data),
    .rd_spi_finsh_h  (rd_spi_finsh_h),
    .rd_spi_datain   (rd_spi_datain),
    .spi_cs_l        (spi_cs_l),
    .spi_en_hp       (spi_en_hp),
    .spi_data        (spi_data),
    .spi_finsh_h     (spi_finsh_h),
    .spi_datain      (spi_datain),
    .busy_h          (busy_h),
    .owner           (owner),
    .timeout_err_hp  (timeout_err_hp)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    cfg_req_h = 0; cfg_cs_l = 1; cfg_spi_en_hp = 0; cfg_spi_data = 8'h00; cfg_done_h = 0;
    rd_req_h = 0; rd_cs_l = 1; rd_spi_en_hp = 0; rd_spi_data = 8'h00;
    spi_finsh_h = 0; spi_datain = 8'h5A;
    tick(2);
    tests_run++;
    if ({cfg_gnt_h, rd_gnt_h, owner, busy_h, timeout_err_hp} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got gnt=%b%b owner=%b busy=%b err=%b required all 0",
               cfg_gnt_h, rd_gnt_h, owner, busy_h, timeout_err_hp);
    end
    tests_run++;
    if ({spi_cs_l, spi_en_hp, spi_data} !== {1'b1, 1'b0, 8'hFF}) begin
      tests_failed++;
      $display("FAIL reset_bus: got cs=%b en=%b data=%h required cs=1 en=0 data=ff",
               spi_cs_l, spi_en_hp, spi_data);
    end
    tests_run++;
    if ({cfg_spi_finsh_h, rd_spi_finsh_h, rd_spi_datain} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_return: got cfin=%b rfin=%b rx=%h required 0 0 00",
               cfg_spi_finsh_h, rd_spi_finsh_h, rd_spi_datain);
    end
    sys_rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_cfg_grant();
    cfg_done_h = 1; cfg_req_h = 1;
    tick(1);
    tests_run++;
    if (cfg_gnt_h !== 1'b1 || owner !== 2'b01) begin
      tests_failed++;
      $display("FAIL cfg_grant: got gnt=%b owner=%b required 1 01", cfg_gnt_h, owner);
    end
    cfg_cs_l = 0; cfg_spi_data = 8'h60; cfg_spi_en_hp = 1;
    spi_finsh_h = 1; spi_datain = 8'h33;
    #1;
    tests_run++;
    if ({spi_cs_l, spi_en_hp, spi_data} !== {1'b0, 1'b1, 8'h60}) begin
      tests_failed++;
      $display("FAIL cfg_mux: got cs=%b en=%b data=%h required 0 1 60", spi_cs_l, spi_en_hp, spi_data);
    end
    tests_run++;
    if ({cfg_spi_finsh_h, rd_spi_finsh_h, rd_spi_datain} !== {1'b1, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL cfg_finish_route: got cfin=%b rfin=%b rx=%h required 1 0 00",
               cfg_spi_finsh_h, rd_spi_finsh_h, rd_spi_datain);
    end
    tick(1);
    cfg_spi_en_hp = 0; spi_finsh_h = 0; cfg_cs_l = 1; cfg_req_h = 0;
    tick(1);
    tests_run++;
    if (cfg_gnt_h !== 1'b0 || busy_h !== 1'b1 || spi_cs_l !== 1'b1) begin
      tests_failed++;
      $display("FAIL cfg_release_gap: got gnt=%b busy=%b cs=%b required 0 1 1", cfg_gnt_h, busy_h, spi_cs_l);
    end
    tick(3);
    tests_run++;
    if (busy_h !== 1'b1) begin
      tests_failed++;
      $display("FAIL gap_last_cycle: got busy=%b required 1", busy_h);
    end
    tick(1);
    tests_run++;
    if (busy_h !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap_to_idle: got busy=%b required 0", busy_h);
    end
  endtask

  task automatic test_priority();
    logic [1:0] prev = 2'b00;
    logic [1:0] exp_own;
    int         high_cnt = 0;
    bit         seen_cfg = 0;
    bit         seen_rd  = 0;
    cfg_cs_l = 0; rd_cs_l = 0;
    own_q.push_back(2'b01);
    own_q.push_back(2'b10);
    cfg_req_h = 1; rd_req_h = 1;
    for (int i = 0; i < 30 && !seen_rd; i++) begin
      tick(1);
      if (owner !== prev && owner !== 2'b00) begin
        tests_run++;
        exp_own = (own_q.size() > 0) ? own_q.pop_front() : 2'b11;
        if (owner !== exp_own) begin
          tests_failed++;
          $display("FAIL grant_order: got owner=%b required %b", owner, exp_own);
        end
      end
      prev = owner;
      if (owner == 2'b01) begin
        seen_cfg  = 1;
        cfg_req_h = 0;
      end else if (owner == 2'b00 && seen_cfg) begin
        high_cnt += (spi_cs_l === 1'b1) ? 1 : 0;
      end else if (owner == 2'b10) begin
        seen_rd  = 1;
        rd_req_h = 0;
      end
    end
    tests_run++;
    if (!seen_rd || own_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rd_after_cfg: got seen_rd=%0d pending=%0d required 1 0", seen_rd, own_q.size());
    end
    tests_run++;
    if (high_cnt != 4) begin
      tests_failed++;
      $display("FAIL gap_len: got %0d cs-high cycles required 4", high_cnt);
    end
    tick(5);
  endtask

  task automatic test_rd_blocked();
    int gnt_seen = 0;
    sys_rst_n = 0; cfg_done_h = 0; cfg_req_h = 0; rd_req_h = 0;
    tick(1);
    sys_rst_n = 1;
    rd_req_h = 1;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (rd_gnt_h === 1'b1 || busy_h === 1'b1) gnt_seen++;
    end
    tests_run++;
    if (gnt_seen != 0) begin
      tests_failed++;
      $display("FAIL rd_blocked: got %0d granted/busy cycles required 0", gnt_seen);
    end
    cfg_done_h = 1;
    tick(1);
    tests_run++;
    if (rd_gnt_h !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_allow_latency: got gnt=%b required 0", rd_gnt_h);
    end
    tick(1);
    tests_run++;
    if (rd_gnt_h !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_unblocked: got gnt=%b required 1", rd_gnt_h);
    end
    rd_req_h = 0;
    tick(6);
  endtask

  task automatic test_read_scoreboard();
    logic [7:0] bytes[3];
    logic [7:0] exp_b;
    int         waited = 0;
    int         cfg_leak = 0;
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h0F;
    rd_req_h = 1; rd_cs_l = 0;
    while (rd_gnt_h !== 1'b1 && waited < 10) begin
      tick(1);
      waited++;
    end
    tests_run++;
    if (rd_gnt_h !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_grant_wait: got gnt=%b required 1 within 10 cycles", rd_gnt_h);
    end
    for (int b = 0; b < 3; b++) begin
      rx_q.push_back(bytes[b]);
      spi_datain  = bytes[b];
      spi_finsh_h = 1;
      #1;
      if (rd_spi_finsh_h === 1'b1) begin
        tests_run++;
        exp_b = rx_q.pop_front();
        if (rd_spi_datain !== exp_b || cfg_spi_finsh_h !== 1'b0) begin
          tests_failed++;
          $display("FAIL rd_rx_byte: got rx=%h cfin=%b required rx=%h cfin=0",
                   rd_spi_datain, cfg_spi_finsh_h, exp_b);
        end
      end
      tick(1);
      spi_finsh_h = 0;
      if (b == 0) cfg_req_h = 1;
      tick(1);
      if (cfg_gnt_h === 1'b1) cfg_leak++;
    end
    tests_run++;
    if (rx_q.size() != 0 || cfg_leak != 0) begin
      tests_failed++;
      $display("FAIL rd_no_preempt: got pending=%0d cfg_grants=%0d required 0 0", rx_q.size(), cfg_leak);
    end
    rd_req_h = 0; rd_cs_l = 1;
    tick(4);
    tests_run++;
    if (cfg_gnt_h !== 1'b0 || spi_cs_l !== 1'b1) begin
      tests_failed++;
      $display("FAIL cfg_wait_gap: got gnt=%b cs=%b required 0 1", cfg_gnt_h, spi_cs_l);
    end
    tick(1);
    tests_run++;
    if (cfg_gnt_h !== 1'b1) begin
      tests_failed++;
      $display("FAIL cfg_after_read: got gnt=%b required 1", cfg_gnt_h);
    end
    cfg_req_h = 0;
    tick(5);
  endtask

  task automatic test_timeout();
    int gcount = 0;
    int errs   = 0;
    cfg_req_h = 1;
    tick(1);
    if (cfg_gnt_h === 1'b1) gcount++;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (cfg_gnt_h === 1'b1) gcount++;
      if (timeout_err_hp === 1'b1) begin
        errs++;
        tests_run++;
        if (cfg_gnt_h !== 1'b0 || owner !== 2'b00 || busy_h !== 1'b1) begin
          tests_failed++;
          $display("FAIL hold_entry: got gnt=%b owner=%b busy=%b required 0 00 1", cfg_gnt_h, owner, busy_h);
        end
      end
    end
    tests_run++;
    if (errs != 1) begin
      tests_failed++;
      $display("FAIL timeout_pulse: got %0d pulses required 1", errs);
    end
    tests_run++;
    if (gcount != 16) begin
      tests_failed++;
      $display("FAIL timeout_len: got %0d granted cycles required 16", gcount);
    end
    cfg_req_h = 0;
    tick(1);
    tests_run++;
    if (busy_h !== 1'b1 || cfg_gnt_h !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_to_gap: got busy=%b gnt=%b required 1 0", busy_h, cfg_gnt_h);
    end
    tick(4);
    tests_run++;
    if (busy_h !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_gap_end: got busy=%b required 0", busy_h);
    end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    int late   = 0;
    rd_req_h = 1; rd_cs_l = 0;
    while (rd_gnt_h !== 1'b1 && waited < 10) begin
      tick(1);
      waited++;
    end
    tests_run++;
    if (rd_gnt_h !== 1'b1 || spi_cs_l !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_grant: got gnt=%b cs=%b required 1 0", rd_gnt_h, spi_cs_l);
    end
    sys_rst_n = 0; cfg_done_h = 0;
    tick(1);
    tests_run++;
    if (rd_gnt_h !== 1'b0 || spi_cs_l !== 1'b1 || owner !== 2'b00 || busy_h !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got gnt=%b cs=%b owner=%b busy=%b required 0 1 00 0",
               rd_gnt_h, spi_cs_l, owner, busy_h);
    end
    sys_rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (rd_gnt_h === 1'b1) late++;
    end
    tests_run++;
    if (late != 0) begin
      tests_failed++;
      $display("FAIL rd_allow_cleared: got %0d rd grants required 0", late);
    end
    cfg_req_h = 1;
    tick(1);
    tests_run++;
    if (cfg_gnt_h !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_gap_after_reset: got gnt=%b required 1", cfg_gnt_h);
    end
    cfg_req_h = 0; rd_req_h = 0;
    tick(5);
  endtask

  initial begin
    test_reset();
    test_cfg_grant();
    test_priority();
    test_rd_blocked();
    test_read_scoreboard();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
